// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: start bit, WIDTH LSB-first data bits, optional even parity.
// Delivers each word through a registered valid/ready output stage with parity/overrun pulses.
module sipo_deframer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             parity_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               parity_err_q, parity_err_d;
  logic               overrun_q, overrun_d;

  logic               frame_done;
  logic [WIDTH-1:0]   frame_word;
  logic               frame_bad_par;

  // Next-state, shift/count and output-stage logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q & ~out_ready_i;
    parity_err_d  = 1'b0;
    overrun_d     = 1'b0;
    frame_done    = 1'b0;
    frame_word    = shift_q;
    frame_bad_par = 1'b0;

    if (bit_valid_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (serial_in_i) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          // Shift right so the first data bit ends up in bit 0
          shift_d = {serial_in_i, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
            end else begin
              state_d    = ST_IDLE;
              frame_done = 1'b1;
              frame_word = shift_d;
            end
          end
        end
        ST_PARITY: begin
          state_d       = ST_IDLE;
          frame_done    = 1'b1;
          frame_word    = shift_q;
          frame_bad_par = (^shift_q) ^ serial_in_i;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A completed frame loads if the output stage is empty or draining this edge
    if (frame_done) begin
      parity_err_d = frame_bad_par;
      if (!out_valid_q || out_ready_i) begin
        out_data_d  = frame_word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: scoreboarded frames with parity, overrun, gaps and mid-frame reset.
module tb_sipo_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bv, si, rdy;
  logic [7:0] out_data;
  logic       out_valid, perr, ovr, busy;
  logic       bv2, si2;
  logic       rdy2 = 1'b1;
  logic [7:0] out_data2;
  logic       out_valid2, perr2, ovr2, busy2;

  int checks = 0;
  int failures = 0;
  int perr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(8), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bit_valid_i(bv), .serial_in_i(si),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(rdy),
    .parity_err_o(perr), .overrun_o(ovr), .busy_o(busy));

  sipo_deframer #(.WIDTH(8), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .bit_valid_i(bv2), .serial_in_i(si2),
    .out_data_o(out_data2), .out_valid_o(out_valid2), .out_ready_i(rdy2),
    .parity_err_o(perr2), .overrun_o(ovr2), .busy_o(busy2));

  // Pulse counters: each one-cycle pulse spans exactly one falling edge
  always @(negedge clk) begin
    if (perr === 1'b1) perr_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
  end

  task automatic drive(input int sel, input logic v, input logic s);
    if (sel == 0) begin bv = v; si = s; end
    else begin bv2 = v; si2 = s; end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one frame; returns at final sampling edge + 1 with bit_valid low
  task automatic send_frame(input int sel, input logic [7:0] w, input bit with_par,
                            input logic par, input int gap);
    logic b[10];
    int n;
    b[0] = 1'b1;
    for (int i = 0; i < 8; i++) b[i+1] = w[i];
    b[9] = par;
    n = with_par ? 10 : 9;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap - 1; g++) begin
          drive(sel, 1'b0, 1'($urandom));
          step();
        end
      end
      drive(sel, 1'b1, b[i]);
      step();
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bv = 1'($urandom); si = 1'($urandom);
      bv2 = 1'($urandom); si2 = 1'($urandom);
      step();
      checks++;
      if ({out_data, out_valid, perr, ovr, busy} !== 12'h0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h expected=000", c,
                 {out_data, out_valid, perr, ovr, busy});
      end
    end
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset busy=%b valid=%b expected 0 0", busy, out_valid);
      end
    end
    drive(0, 1'b0, 1'b0);
    exp = 8'h00;
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL idle_data got=%h expected=%h", out_data, exp);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp;
    rdy = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1);
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      failures++;
      $display("FAIL good_frame valid=%b data=%h expected 1 %h", out_valid, out_data, exp);
    end
    checks++;
    if (perr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL good_frame_flags perr=%b busy=%b expected 0 0", perr, busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL good_frame_valid_width valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_parity_err();
    logic [7:0] exp;
    int p0;
    p0 = perr_cnt;
    rdy = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 1);
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp || perr !== 1'b1) begin
      failures++;
      $display("FAIL parity_err valid=%b data=%h perr=%b expected 1 %h 1",
               out_valid, out_data, perr, exp);
    end
    step();
    checks++;
    if (perr !== 1'b0 || (perr_cnt - p0) != 1) begin
      failures++;
      $display("FAIL parity_err_pulse perr=%b pulses=%0d expected 0 1", perr, perr_cnt - p0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    int o0;
    o0 = ovr_cnt;
    rdy = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0] || ovr !== 1'b0) begin
      failures++;
      $display("FAIL overrun_first valid=%b data=%h ovr=%b expected 1 %h 0",
               out_valid, out_data, ovr, exp_q[0]);
    end
    send_frame(0, 8'hF0, 1'b1, 1'b0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0] || ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_drop valid=%b data=%h ovr=%b expected 1 %h 1",
               out_valid, out_data, ovr, exp_q[0]);
    end
    step();
    checks++;
    if (ovr !== 1'b0 || (ovr_cnt - o0) != 1 || out_data !== exp_q[0]) begin
      failures++;
      $display("FAIL overrun_pulse ovr=%b pulses=%0d data=%h expected 0 1 %h",
               ovr, ovr_cnt - o0, out_data, exp_q[0]);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL overrun_consume_data got=%h expected=%h", out_data, exp);
    end
    rdy = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_consume valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] exp;
    rdy = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(0, 8'h81, 1'b1, 1'b0, 3);
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp || perr !== 1'b0) begin
      failures++;
      $display("FAIL gaps_par valid=%b data=%h perr=%b expected 1 %h 0",
               out_valid, out_data, perr, exp);
    end
    exp_q.push_back(8'h81);
    send_frame(1, 8'h81, 1'b0, 1'b0, 3);
    exp = exp_q.pop_front();
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== exp || perr2 !== 1'b0) begin
      failures++;
      $display("FAIL gaps_nopar valid=%b data=%h perr=%b expected 1 %h 0",
               out_valid2, out_data2, perr2, exp);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3];
    logic [7:0] exp;
    words[0] = 8'h55; words[1] = 8'h0F; words[2] = 8'hC3;
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(words[k]);
      send_frame(0, words[k], 1'b1, ^words[k], 1);
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || perr !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back k=%0d valid=%b data=%h perr=%b expected 1 %h 0",
                 k, out_valid, out_data, perr, exp);
      end
    end
    step();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp;
    int p0, o0;
    p0 = perr_cnt;
    o0 = ovr_cnt;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b1);
      step();
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_busy got=%b expected=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset busy=%b valid=%b data=%h expected 0 0 00",
               busy, out_valid, out_data);
    end
    drive(0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(8'h12);
    send_frame(0, 8'h12, 1'b1, 1'b0, 1);
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      failures++;
      $display("FAIL after_reset_frame valid=%b data=%h expected 1 %h", out_valid, out_data, exp);
    end
    step();
    checks++;
    if ((perr_cnt - p0) != 0 || (ovr_cnt - o0) != 0) begin
      failures++;
      $display("FAIL midframe_flags perr_pulses=%0d ovr_pulses=%0d expected 0 0",
               perr_cnt - p0, ovr_cnt - o0);
    end
  endtask

  initial begin
    bv = 1'b0; si = 1'b0; bv2 = 1'b0; si2 = 1'b0; rdy = 1'b1; rst_n = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_overrun();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
